write_channel_arbiter: RTL and testbench

//  Shares one native write-channel port (valid/addr/wdata/wstrb/ready) between N_REQ requesters,
//  e.g. the write-through buffer and an uncached/MMIO write path. Round-robin grant, one write in

---
 rtl/write_channel_arbiter.sv | 115 +++++++++++
 tb/tb_write_channel_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/write_channel_arbiter.sv
// Round-robin arbiter sharing one native write-channel port between N_REQ
// requesters. One write in flight; payload latched at grant and held until
// the channel signals completion on wr_ready.
module write_channel_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int NBYTES = DATA_W/8,
  parameter int N_REQ  = 2,
  parameter int ID_W   = ($clog2(N_REQ) > 0) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  input  logic [N_REQ*NBYTES-1:0] req_wstrb,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    wr_valid,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_wdata,
  output logic [NBYTES-1:0]       wr_wstrb,
  input  logic                    wr_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   grant_q, last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NBYTES-1:0] wstrb_q;

  // Per-requester payload views of the flattened input buses
  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];
  logic [NBYTES-1:0] wstrb_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr [g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    assign wstrb_a[g] = req_wstrb[g*NBYTES +: NBYTES];
  end

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  int              scan_idx;

  // Round-robin pick: first pending requester after the last one served
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = int'(last_grant_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(scan_idx);
      end
    end
  end

  wire grant_now = (state_q == S_IDLE) && win_found && wr_ready;
  wire done_now  = (state_q == S_WAIT) && wr_ready;

  // Next-state: grant only when the channel is idle; LAUNCH lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_now) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (wr_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, grant bookkeeping and payload latch (loaded only on grant)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        grant_q <= win_idx;
        addr_q  <= addr_a[win_idx];
        wdata_q <= wdata_a[win_idx];
        wstrb_q <= wstrb_a[win_idx];
      end
      if (done_now) last_grant_q <= grant_q;
    end
  end

  // Completion pulse goes straight back to the owner in the wr_ready cycle
  always_comb begin
    req_ready = '0;
    if (done_now) req_ready[grant_q] = 1'b1;
  end

  assign wr_valid = (state_q == S_LAUNCH);
  assign wr_addr  = addr_q;
  assign wr_wdata = wdata_q;
  assign wr_wstrb = wstrb_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_write_channel_arbiter.sv
// Directed, table-driven bench for write_channel_arbiter (N_REQ=2).
// Each table row drives inputs for one cycle and checks outputs mid-cycle.
module tb_write_channel_arbiter;

  localparam logic [31:0] DA = 32'hA5A5A5A5;
  localparam logic [31:0] DB = 32'h12345678;
  localparam logic [31:0] DD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [59:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_ready;
  logic        wr_valid;
  logic [29:0] wr_addr;
  logic [31:0] wr_wdata;
  logic [3:0]  wr_wstrb;
  logic        wr_ready;
  logic [0:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  write_channel_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_ready(req_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
    .wr_wstrb(wr_wstrb), .wr_ready(wr_ready),
    .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rv;
    logic        rdy;
    logic [31:0] wd0;
    logic        wv;
    logic [1:0]  rr;
    logic        bsy;
    logic        gid;
    logic [29:0] wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rst, input logic [1:0] rv, input logic rdy,
                     input logic [31:0] wd0, input logic wv, input logic [1:0] rr,
                     input logic bsy, input logic gid, input logic [29:0] wa,
                     input logic [31:0] wd);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rdy = rdy; v.wd0 = wd0; v.wv = wv; v.rr = rr;
    v.bsy = bsy; v.gid = gid; v.wa = wa; v.wd = wd;
    tv.push_back(v);
  endtask

  // Requester 0 strobes 4'hF at 0x10, requester 1 strobes 4'h3 at 0x20
  function automatic logic [3:0] strb_of(input logic [29:0] a);
    if (a == 30'h10) return 4'hF;
    if (a == 30'h20) return 4'h3;
    return 4'h0;
  endfunction

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [1:0] rv, input logic rdy,
                       input logic [31:0] wd0);
    reset     = rst;
    req_valid = rv;
    wr_ready  = rdy;
    req_wdata = {DB, wd0};
  endtask

  initial begin
    req_addr  = {30'h20, 30'h10};
    req_wstrb = {4'h3, 4'hF};
    drive(1'b1, 2'b00, 1'b1, DA);

    // 1: single request, completion after several WAIT cycles
    add(1,0,1,DA, 0,0,0,0,30'h00,0);
    add(0,1,1,DA, 0,0,0,0,30'h00,0);
    add(0,1,0,DA, 1,0,1,0,30'h10,DA);
    for (int i = 0; i < 3; i++) add(0,1,0,DA, 0,0,1,0,30'h10,DA);
    add(0,1,1,DA, 0,1,1,0,30'h10,DA);
    add(0,0,1,DA, 0,0,0,0,30'h10,DA);
    // 2: both requesting from reset, order 0,1,0,1
    add(1,3,1,DA, 0,0,0,0,30'h00,0);
    add(0,3,1,DA, 0,0,0,0,30'h00,0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) add(0,3,1,DA, 0,0,0,1,30'h20,DB);
      add(0,3,0,DA, 1,0,1,0,30'h10,DA);
      add(0,3,1,DA, 0,1,1,0,30'h10,DA);
      add(0,3,1,DA, 0,0,0,0,30'h10,DA);
      add(0,3,0,DA, 1,0,1,1,30'h20,DB);
      add(0,3,1,DA, 0,2,1,1,30'h20,DB);
    end
    add(0,0,1,DA, 0,0,0,1,30'h20,DB);
    // 3: lone requester 1 re-granted back-to-back, one IDLE cycle between
    for (int i = 0; i < 3; i++) begin
      add(0,2,1,DA, 0,0,0,1,30'h20,DB);
      add(0,2,0,DA, 1,0,1,1,30'h20,DB);
      add(0,2,1,DA, 0,2,1,1,30'h20,DB);
    end
    add(0,0,1,DA, 0,0,0,1,30'h20,DB);
    // 4: channel not idle -> no grant
    for (int i = 0; i < 3; i++) add(0,1,0,DA, 0,0,0,1,30'h20,DB);
    add(0,1,1,DA, 0,0,0,1,30'h20,DB);
    add(0,1,0,DA, 1,0,1,0,30'h10,DA);
    // 5: payload change while granted is ignored
    add(0,1,0,DD, 0,0,1,0,30'h10,DA);
    add(0,1,0,DD, 0,0,1,0,30'h10,DA);
    add(0,1,1,DD, 0,1,1,0,30'h10,DA);
    add(0,0,1,DA, 0,0,0,0,30'h10,DA);

    for (int r = 0; r < tv.size(); r++) begin
      @(posedge clk); #1;
      drive(tv[r].rst, tv[r].rv, tv[r].rdy, tv[r].wd0);
      @(negedge clk);
      check($sformatf("row%0d", r),
            {wr_valid, req_ready, busy, grant_id, wr_addr, wr_wdata, wr_wstrb},
            {tv[r].wv, tv[r].rr, tv[r].bsy, tv[r].gid, tv[r].wa, tv[r].wd, strb_of(tv[r].wa)});
    end

    // 6: reset asserted mid-WAIT clears everything at once, no completion pulse
    @(posedge clk); #1; drive(1'b0, 2'b11, 1'b1, DA);   // IDLE, last_grant=0 -> req1
    @(posedge clk); #1; drive(1'b0, 2'b11, 1'b0, DA);   // LAUNCH
    @(negedge clk);
    check("pre_rst_launch", {wr_valid, grant_id, wr_addr}, {1'b1, 1'b1, 30'h20});
    @(posedge clk); #2;                                  // in WAIT
    check("pre_rst_wait", {busy, grant_id}, {1'b1, 1'b1});
    drive(1'b1, 2'b11, 1'b1, DA);
    #1;
    check("rst_mid_wait",
          {wr_valid, req_ready, busy, grant_id, wr_addr, wr_wdata, wr_wstrb},
          71'd0);
    @(posedge clk); #1; drive(1'b0, 2'b11, 1'b1, DA);
    @(posedge clk); #1; drive(1'b0, 2'b11, 1'b0, DA);
    check("post_rst_winner", {wr_valid, busy, grant_id, wr_addr, wr_wdata},
          {1'b1, 1'b1, 1'b0, 30'h10, DA});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
